// File: rtl/fifo_drain_if.sv
// Handshake bundle between fifo_drain, its source FIFO and the downstream byte stream.
// slave: the drain controller's view; master: the environment's view.
interface fifo_drain_if #(
   parameter int unsigned WIDTH = 8
);
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_data;
   logic             fifo_rd_en;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport slave (
      input  fifo_empty, fifo_data, out_ready,
      output fifo_rd_en, out_data, out_valid
   );

   modport master (
      output fifo_empty, fifo_data, out_ready,
      input  fifo_rd_en, out_data, out_valid
   );
endinterface

// File: rtl/fifo_drain.sv
// Read-side controller for the 8-entry byte FIFO. Issues reads while the skid
// buffer can absorb the FIFO's one-cycle read latency, presents bytes on a
// valid/ready stream and counts bytes handed downstream.
module fifo_drain #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned SKID_DEPTH = 2,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   fifo_drain_if.slave      bus,
   output logic [CNT_W-1:0] drained_cnt,
   output logic             busy
);

   localparam int unsigned PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam int unsigned OW = $clog2(SKID_DEPTH + 1);
   localparam int unsigned LW = OW + 1;

   logic [WIDTH-1:0] mem_q [SKID_DEPTH];
   logic [WIDTH-1:0] mem_d [SKID_DEPTH];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [OW-1:0]    occ_q, occ_d;
   logic             pending_q, pending_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             pop;
   logic             capture;
   logic             rd_en;
   logic [LW-1:0]    level;

   // Circular pointer advance that also works for non-power-of-two depths.
   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign bus.out_valid  = (occ_q != '0);
   assign bus.out_data   = mem_q[head_q];
   assign bus.fifo_rd_en = rd_en;
   assign drained_cnt    = cnt_q;
   assign busy           = pending_q || (occ_q != '0);

   // Read issue, skid capture/pop and counter next-state.
   always_comb begin
      pop     = bus.out_valid && bus.out_ready;
      capture = pending_q;
      // Entries committed after this edge: held + arriving - leaving.
      level   = LW'(occ_q) + LW'(pending_q) - LW'(pop);
      rd_en   = rst_n && enable && !bus.fifo_empty && (level < LW'(SKID_DEPTH));

      mem_d = mem_q;
      if (capture) mem_d[tail_q] = bus.fifo_data;

      tail_d    = capture ? bump(tail_q) : tail_q;
      head_d    = pop ? bump(head_q) : head_q;
      occ_d     = occ_q + OW'(capture) - OW'(pop);
      pending_d = rd_en;
      cnt_d     = cnt_q + CNT_W'(pop);
   end

   // State registers; reset discards any in-flight read along with the skid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         occ_q     <= '0;
         pending_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= mem_d[i];
         head_q    <= head_d;
         tail_q    <= tail_d;
         occ_q     <= occ_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
      end
   end

   // A capture into a full skid without a simultaneous pop must never happen.
   always_ff @(posedge clk) begin
      if (rst_n) assert (!(pending_q && (occ_q == OW'(SKID_DEPTH)) && !pop));
   end

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain with a behavioural 8-entry registered-read FIFO.
// A second instance with CNT_W = 4 shares the stimulus for the counter wrap check.
module tb_fifo_drain;

   logic clk;
   logic rst_n;
   logic enable;
   logic ready;

   logic [7:0]  fmem [8];
   logic [3:0]  wp    = '0;
   logic [3:0]  rp    = '0;
   logic [7:0]  fdata = '0;
   logic        fempty;

   logic [15:0] cnt16;
   logic        busy16;
   logic [3:0]  cnt4;
   logic        busy4;

   int n_assert = 0;
   int n_fail   = 0;
   int reads;
   int nxt;

   fifo_drain_if #(.WIDTH(8)) bus ();
   fifo_drain_if #(.WIDTH(8)) bus4 ();

   assign fempty         = (wp == rp);
   assign bus.fifo_empty  = fempty;
   assign bus.fifo_data   = fdata;
   assign bus.out_ready   = ready;
   assign bus4.fifo_empty = fempty;
   assign bus4.fifo_data  = fdata;
   assign bus4.out_ready  = ready;

   fifo_drain #(.WIDTH(8), .SKID_DEPTH(2), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
      .drained_cnt(cnt16), .busy(busy16)
   );

   fifo_drain #(.WIDTH(8), .SKID_DEPTH(2), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus4),
      .drained_cnt(cnt4), .busy(busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO model: registered read data, flushed by the shared reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rp    <= wp;
         fdata <= '0;
      end else if (bus.fifo_rd_en) begin
         fdata <= fmem[rp[2:0]];
         rp    <= rp + 4'd1;
      end
   end

   task automatic push(input logic [7:0] b);
      fmem[wp[2:0]] = b;
      wp = wp + 4'd1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      enable = 1'b0;
      ready  = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
   endtask

   initial begin
      rst_n  = 1'b0;
      enable = 1'b0;
      ready  = 1'b0;

      // Reset state, including rd_en held low while a byte is available.
      repeat (2) @(negedge clk);
      push(8'hEE);
      enable = 1'b1;
      #1;
      chk("rst_valid",  32'(bus.out_valid), 32'd0);
      chk("rst_data",   32'(bus.out_data), 32'h00);
      chk("rst_cnt",    32'(cnt16), 32'd0);
      chk("rst_rd_en",  32'(bus.fifo_rd_en), 32'd0);
      chk("rst_busy",   32'(busy16), 32'd0);
      chk("rst_rd_en4", 32'(bus4.fifo_rd_en), 32'd0);
      do_reset();

      // Single byte.
      push(8'hA5);
      enable = 1'b1;
      ready  = 1'b1;
      #1;
      chk("one_rd_c0", 32'(bus.fifo_rd_en), 32'd1);
      @(negedge clk); #1;
      chk("one_rd_c1",    32'(bus.fifo_rd_en), 32'd0);
      chk("one_valid_c1", 32'(bus.out_valid), 32'd0);
      chk("one_busy_c1",  32'(busy16), 32'd1);
      @(negedge clk); #1;
      chk("one_valid_c2", 32'(bus.out_valid), 32'd1);
      chk("one_data_c2",  32'(bus.out_data), 32'hA5);
      @(negedge clk); #1;
      chk("one_valid_c3", 32'(bus.out_valid), 32'd0);
      chk("one_cnt",      32'(cnt16), 32'd1);
      chk("one_busy_c3",  32'(busy16), 32'd0);

      // Full burst at one byte per clock.
      do_reset();
      for (int i = 1; i <= 8; i++) push(8'(i));
      enable = 1'b1;
      ready  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("burst_rd", 32'(bus.fifo_rd_en), (i < 8) ? 32'd1 : 32'd0);
         if (i >= 2) begin
            chk("burst_valid", 32'(bus.out_valid), 32'd1);
            chk("burst_data",  32'(bus.out_data), 32'(i - 1));
         end else begin
            chk("burst_valid", 32'(bus.out_valid), 32'd0);
         end
         @(negedge clk);
      end
      #1;
      chk("burst_valid_end", 32'(bus.out_valid), 32'd0);
      chk("burst_cnt",       32'(cnt16), 32'd8);
      chk("burst_busy",      32'(busy16), 32'd0);

      // Backpressure: only two reads fit, head frozen, then toggled ready.
      do_reset();
      for (int i = 1; i <= 8; i++) push(8'(i));
      enable = 1'b1;
      ready  = 1'b0;
      reads  = 0;
      for (int s = 0; s < 10; s++) begin
         #1;
         if (bus.fifo_rd_en) reads++;
         @(negedge clk);
      end
      #1;
      chk("bp_reads", 32'(reads), 32'd2);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_data",  32'(bus.out_data), 32'h01);
      chk("bp_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      nxt = 0;
      for (int s = 0; s < 40 && nxt < 8; s++) begin
         @(negedge clk);
         ready = s[0];
         #1;
         if (bus.out_valid) begin
            chk("bp_order", 32'(bus.out_data), 32'(nxt + 1));
            if (ready) nxt++;
         end
      end
      @(negedge clk); #1;
      chk("bp_count", 32'(nxt), 32'd8);
      chk("bp_cnt",   32'(cnt16), 32'd8);
      chk("bp_busy",  32'(busy16), 32'd0);

      // Enable dropped right after a read: the in-flight byte still arrives.
      do_reset();
      push(8'h10); push(8'h11); push(8'h12); push(8'h13);
      enable = 1'b1;
      ready  = 1'b1;
      #1;
      chk("en_rd_c0", 32'(bus.fifo_rd_en), 32'd1);
      @(negedge clk);
      enable = 1'b0;
      #1;
      chk("en_rd_c1",   32'(bus.fifo_rd_en), 32'd0);
      chk("en_busy_c1", 32'(busy16), 32'd1);
      @(negedge clk); #1;
      chk("en_valid_c2", 32'(bus.out_valid), 32'd1);
      chk("en_data_c2",  32'(bus.out_data), 32'h10);
      chk("en_rd_c2",    32'(bus.fifo_rd_en), 32'd0);
      @(negedge clk); #1;
      chk("en_valid_c3", 32'(bus.out_valid), 32'd0);
      chk("en_busy_c3",  32'(busy16), 32'd0);
      chk("en_cnt_c3",   32'(cnt16), 32'd1);
      chk("en_rd_c3",    32'(bus.fifo_rd_en), 32'd0);
      @(negedge clk);
      enable = 1'b1;
      #1;
      chk("en_rd_c4", 32'(bus.fifo_rd_en), 32'd1);
      repeat (8) @(negedge clk);
      #1;
      chk("en_cnt_end",  32'(cnt16), 32'd4);
      chk("en_busy_end", 32'(busy16), 32'd0);

      // Asynchronous reset in the middle of a burst.
      do_reset();
      for (int i = 1; i <= 8; i++) push(8'(i));
      enable = 1'b1;
      ready  = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      chk("mid_valid_pre", 32'(bus.out_valid), 32'd1);
      chk("mid_data_pre",  32'(bus.out_data), 32'h04);
      chk("mid_cnt_pre",   32'(cnt16), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_data",  32'(bus.out_data), 32'h00);
      chk("mid_cnt",   32'(cnt16), 32'd0);
      chk("mid_busy",  32'(busy16), 32'd0);
      chk("mid_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      chk("mid_cnt4",  32'(cnt4), 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      enable = 1'b0;
      ready  = 1'b0;

      // Counter wrap: 17 bytes in chunks that fit the 8-entry FIFO.
      for (int ch = 0; ch < 3; ch++) begin
         @(negedge clk);
         for (int k = 0; k < ((ch == 2) ? 1 : 8); k++) push(8'(8'h40 + ch * 8 + k));
         enable = 1'b1;
         ready  = 1'b1;
         repeat (12) @(negedge clk);
      end
      #1;
      chk("wrap_cnt16", 32'(cnt16), 32'd17);
      chk("wrap_cnt4",  32'(cnt4), 32'd1);
      chk("wrap_busy",  32'(busy4), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
